// File: rtl/perf_snapshot_streamer.sv
// Snapshot streamer: captures every counter of the perf bank on the same edge
// and streams them out one word per counter, as absolute values or deltas.

module perf_snap_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic [W-1:0] count,
  input  logic         delta_mode,
  output logic [W-1:0] word
);
  logic [W-1:0] snap;
  logic [W-1:0] prev_snap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap      <= '0;
      prev_snap <= '0;
    end else if (capture) begin
      prev_snap <= snap;
      snap      <= count;
    end
  end

  // Modular subtraction gives the correct delta across counter wrap.
  assign word = delta_mode ? (snap - prev_snap) : snap;
endmodule

module perf_snapshot_streamer #(
  parameter int COUNTER_WIDTH  = 32,
  parameter int COUNTER_COUNT  = 8,
  parameter int INTERVAL_WIDTH = 16,
  parameter int IDX_WIDTH      = $clog2(COUNTER_COUNT)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [COUNTER_COUNT*COUNTER_WIDTH-1:0] all_counts,
  input  logic                                   sample_en,
  input  logic [INTERVAL_WIDTH-1:0]              interval,
  input  logic                                   trigger,
  input  logic                                   delta_mode,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [COUNTER_WIDTH-1:0]               out_data,
  output logic [IDX_WIDTH-1:0]                   out_index,
  output logic                                   out_last,
  output logic                                   busy,
  output logic [7:0]                             overrun_count
);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(COUNTER_COUNT - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                    state, state_d;
  logic [IDX_WIDTH-1:0]      idx, idx_d;
  logic [7:0]                ovr, ovr_d;
  logic [INTERVAL_WIDTH-1:0] timer;
  logic                      timer_on, tick, req, capture;

  logic [COUNTER_COUNT-1:0][COUNTER_WIDTH-1:0] lane_word;

  // Interval timer runs in every state so the sample period stays regular.
  assign timer_on = sample_en && (interval != '0);
  assign tick     = timer_on && (timer == interval - INTERVAL_WIDTH'(1));
  assign req      = tick || trigger;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 timer <= '0;
    else if (!timer_on || tick) timer <= '0;
    else                     timer <= timer + INTERVAL_WIDTH'(1);
  end

  genvar g;
  generate
    for (g = 0; g < COUNTER_COUNT; g++) begin : g_lane
      perf_snap_lane #(.W(COUNTER_WIDTH)) u_lane (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture),
        .count      (all_counts[g*COUNTER_WIDTH +: COUNTER_WIDTH]),
        .delta_mode (delta_mode),
        .word       (lane_word[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      ovr   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      ovr   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    ovr_d   = ovr;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        // Requests arriving mid-stream (including on the final transfer) are dropped.
        if (req && ovr != 8'hFF) ovr_d = ovr + 8'd1;
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx + IDX_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state == STREAM);
  assign out_valid     = busy;
  assign out_index     = idx;
  assign out_last      = busy && (idx == LAST_IDX);
  assign out_data      = lane_word[idx];
  assign overrun_count = ovr;
endmodule

// File: tb/tb_perf_snapshot_streamer.sv
// Randomized scoreboard bench for perf_snapshot_streamer with a behavioural model.

module tb_perf_snapshot_streamer;
  localparam int W  = 32;
  localparam int CC = 8;
  localparam int IW = 16;
  localparam int XW = $clog2(CC);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CC*W-1:0] all_counts = '0;
  logic            sample_en = 1'b0;
  logic [IW-1:0]   interval = '0;
  logic            trigger = 1'b0;
  logic            delta_mode = 1'b0;
  logic            out_ready = 1'b0;
  logic            out_valid, out_last, busy;
  logic [W-1:0]    out_data;
  logic [XW-1:0]   out_index;
  logic [7:0]      overrun_count;

  perf_snapshot_streamer #(.COUNTER_WIDTH(W), .COUNTER_COUNT(CC), .INTERVAL_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .all_counts(all_counts), .sample_en(sample_en),
    .interval(interval), .trigger(trigger), .delta_mode(delta_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
  endtask

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    bit           last;
  } word_t;

  word_t exp_q[$];

  // Reference model: snapshot arrays, remaining words in the current stream,
  // dropped-request count and sample-period timer.
  logic [W-1:0] snap_m [CC];
  logic [W-1:0] prev_m [CC];
  int left_m = 0;
  int ovr_m = 0;
  int timer_m = 0;

  always @(negedge clk) begin
    bit tick, req;
    word_t w;
    if (rst) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun_count, 0);
      chk("rst_index", out_index, 0);
      chk("rst_last", out_last, 0);
      chk("rst_data", out_data, 0);
      for (int i = 0; i < CC; i++) begin snap_m[i] = '0; prev_m[i] = '0; end
      left_m = 0; ovr_m = 0; timer_m = 0;
      exp_q.delete();
    end else begin
      chk("busy", busy, left_m > 0);
      chk("valid", out_valid, left_m > 0);
      chk("overrun", overrun_count, ovr_m);
      tick = sample_en && (interval != 0) && (timer_m == int'(interval) - 1);
      req  = tick || trigger;
      if (left_m == 0) begin
        if (req) begin
          for (int i = 0; i < CC; i++) begin
            prev_m[i] = snap_m[i];
            snap_m[i] = all_counts[i*W +: W];
          end
          for (int i = 0; i < CC; i++) begin
            w.data = delta_mode ? snap_m[i] - prev_m[i] : snap_m[i];
            w.idx  = i;
            w.last = (i == CC - 1);
            exp_q.push_back(w);
          end
          left_m = CC;
        end
      end else begin
        if (req && ovr_m < 255) ovr_m++;
        if (out_ready) left_m--;
      end
      if (!sample_en || interval == 0 || tick) timer_m = 0;
      else timer_m++;
    end
  end

  // Monitor: pops on every transfer, checks stability while stalled.
  bit           held = 0;
  logic [W-1:0] h_data;
  logic [XW-1:0] h_idx;

  always @(negedge clk) begin
    word_t w;
    if (rst) held = 0;
    else if (out_valid) begin
      if (held) begin
        chk("stall_data", out_data, h_data);
        chk("stall_index", out_index, h_idx);
      end
      if (out_ready) begin
        held = 0;
        if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("data", out_data, w.data);
          chk("index", out_index, w.idx);
          chk("last", out_last, w.last);
        end
      end else begin
        held = 1;
        h_data = out_data;
        h_idx = out_index;
      end
    end else held = 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      step();
      n++;
    end
    chk("wait_idle_timeout", busy, 0);
  endtask

  task automatic set_cnt(input int i, input logic [W-1:0] v);
    all_counts[i*W +: W] = v;
  endtask

  initial begin
    logic [W-1:0] v;
    repeat (3) step();
    rst = 1'b0;
    step();

    // 1: absolute values 100..800
    for (int i = 0; i < CC; i++) set_cnt(i, W'(100 * (i + 1)));
    delta_mode = 1'b0;
    out_ready = 1'b1;
    pulse();
    wait_idle(40);
    step();

    // 2: deltas of 5, then wrap-around on counter 0
    for (int i = 0; i < CC; i++) begin
      v = all_counts[i*W +: W];
      set_cnt(i, v + W'(5));
    end
    delta_mode = 1'b1;
    pulse();
    wait_idle(40);
    set_cnt(0, 32'hFFFF_FFFE);
    pulse();
    wait_idle(40);
    set_cnt(0, 32'h0000_0003);
    pulse();
    wait_idle(40);

    // 3: periodic sampling, then interval 0
    sample_en = 1'b1;
    interval = 16'd20;
    repeat (70) step();
    interval = 16'd0;
    repeat (30) step();
    sample_en = 1'b0;
    wait_idle(40);

    // 4: stalled stream, ready pattern 1,0,0,1
    delta_mode = 1'b0;
    for (int i = 0; i < CC; i++) set_cnt(i, $urandom);
    pulse();
    for (int k = 0; k < 40 && busy; k++) begin
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      step();
    end
    out_ready = 1'b1;
    wait_idle(40);

    // 5: overruns while stalled, saturation at 255
    out_ready = 1'b0;
    pulse();
    step();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < CC; i++) set_cnt(i, $urandom);
      pulse();
      step();
    end
    chk("overrun_3", overrun_count, 3);
    trigger = 1'b1;
    repeat (300) step();
    trigger = 1'b0;
    chk("overrun_sat", overrun_count, 255);
    out_ready = 1'b1;
    wait_idle(40);

    // 6: reset at index 3, then delta stream equals absolute values
    for (int i = 0; i < CC; i++) set_cnt(i, $urandom);
    pulse();
    for (int k = 0; k < 20 && !(busy && out_index == XW'(3)); k++) step();
    chk("reach_index3", out_index, 3);
    #1 rst = 1'b1;
    #1 chk("async_rst_valid", out_valid, 0);
    step();
    rst = 1'b0;
    delta_mode = 1'b1;
    pulse();
    wait_idle(40);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(3) == 0) set_cnt($urandom_range(CC - 1), $urandom);
      trigger = ($urandom_range(7) == 0);
      out_ready = ($urandom_range(3) != 0);
      if (!busy && $urandom_range(3) == 0) delta_mode = $urandom_range(1);
      if (k % 150 == 0) begin
        sample_en = $urandom_range(1);
        interval = IW'($urandom_range(12));
      end
      step();
    end
    trigger = 1'b0;
    sample_en = 1'b0;
    out_ready = 1'b1;
    step();
    wait_idle(40);
    step();
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
